matmul_unit: RTL and testbench

Multi-cycle 2x2 signed 8-bit matrix-multiply coprocessor beside the Execute stage of the RISC-V pipeline. It captures two packed operands from Execute when a matmul instruction issues, computes C = A x B on one shared MAC, and writes a saturated packed result to the register file. It is the sole source of `MatmulBusy`, which the hazard unit uses to stall Fetch/Decode and flush Execute.

---
 rtl/matmul_pkg.sv | 36 +++
 rtl/matmul_mac.sv | 50 +++++
 rtl/matmul_unit.sv | 116 +++++++++++
 tb/tb_matmul_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types, constants and byte-lane helpers for the 2x2 signed matrix-multiply coprocessor.
package matmul_pkg;

  localparam int PKG_EW   = 8;
  localparam int PKG_ACCW = 2 * PKG_EW + 1;
  localparam int SAT_MAX  = 127;
  localparam int SAT_MIN  = -128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Lane of A[i][k] and B[k][j] for a MAC step, with i=cnt[2], j=cnt[1], k=cnt[0].
  function automatic logic [1:0] a_lane(input logic [2:0] cnt);
    return {cnt[2], cnt[0]};
  endfunction

  function automatic logic [1:0] b_lane(input logic [2:0] cnt);
    return {cnt[0], cnt[1]};
  endfunction

  function automatic logic [PKG_EW-1:0] get_lane(input logic [31:0] w, input logic [1:0] idx);
    return w[idx*PKG_EW +: PKG_EW];
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [PKG_EW-1:0] v);
    logic [31:0] r;
    r = w;
    r[idx*PKG_EW +: PKG_EW] = v;
    return r;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single shared signed multiply-accumulate with clear and a saturated view of acc + product.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int EW   = PKG_EW,
  parameter int ACCW = PKG_ACCW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic                 i_last,
  input  logic signed [EW-1:0] i_a,
  input  logic signed [EW-1:0] i_b,
  output logic signed [EW-1:0] o_sat
);

  localparam logic signed [ACCW-1:0] LP_MAX = ACCW'(SAT_MAX);
  localparam logic signed [ACCW-1:0] LP_MIN = ACCW'(SAT_MIN);

  logic signed [ACCW-1:0]   r_acc;
  logic signed [2*EW-1:0]   w_prod;
  logic signed [ACCW-1:0]   w_prod_ext;
  logic signed [ACCW-1:0]   w_sum;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACCW-2*EW){w_prod[2*EW-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;

  // The element output includes the current term so it can be stored on the k=1 step.
  always_comb begin
    o_sat = w_sum[EW-1:0];
    if (w_sum > LP_MAX) begin
      o_sat = LP_MAX[EW-1:0];
    end else if (w_sum < LP_MIN) begin
      o_sat = LP_MIN[EW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear || (i_en && i_last)) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/matmul_unit.sv
// 2x2 signed 8-bit matmul coprocessor beside Execute: latch operands, 8 MAC steps, one write-back.
//   state  | meaning
//   S_IDLE | waiting for MatmulE; busy only in the issue cycle
//   S_MAC  | cnt 0..7, one product per cycle, element stored every second cycle
//   S_WB   | result presented, write enable if rd != 0
module matmul_unit
  import matmul_pkg::*;
#(
  parameter int EW   = PKG_EW,
  parameter int ACCW = PKG_ACCW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MatmulE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  RdE,
  output logic        MatmulBusy,
  output logic        MatmulWeW,
  output logic [4:0]  MatmulRdW,
  output logic [31:0] MatmulResultW
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic [2:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic [31:0] r_work;
  logic [31:0] r_result_w;
  logic [4:0]  r_rd_w;
  logic        w_mac_en;
  logic        w_last;
  logic [EW-1:0] w_a_el;
  logic [EW-1:0] w_b_el;
  logic [EW-1:0] w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MatmulE) begin
          w_start     = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC:   if (r_cnt == 3'd7) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_mac_en = (r_state == S_MAC);
  assign w_last   = r_cnt[0];
  assign w_a_el   = get_lane(r_a, a_lane(r_cnt));
  assign w_b_el   = get_lane(r_b, b_lane(r_cnt));

  matmul_mac #(
    .EW   (EW),
    .ACCW (ACCW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start),
    .i_en    (w_mac_en),
    .i_last  (w_last),
    .i_a     (w_a_el),
    .i_b     (w_b_el),
    .o_sat   (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_work     <= '0;
      r_result_w <= '0;
      r_rd_w     <= '0;
    end else if (w_start) begin
      r_a    <= SrcAE;
      r_b    <= SrcBE;
      r_rd   <= RdE;
      r_cnt  <= '0;
      r_work <= '0;
    end else if (w_mac_en) begin
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_work <= set_lane(r_work, r_cnt[2:1], w_sat);
      end
      // Last element bypasses r_work so the packed result is ready during WB.
      if (r_cnt == 3'd7) begin
        r_result_w <= set_lane(r_work, 2'd3, w_sat);
        r_rd_w     <= r_rd;
      end
    end
  end

  assign MatmulBusy    = w_start | (r_state != S_IDLE);
  assign MatmulWeW     = (r_state == S_WB) && (r_rd != 5'd0);
  assign MatmulRdW     = r_rd_w;
  assign MatmulResultW = r_result_w;

endmodule

// File: tb/tb_matmul_unit.sv
// Self-checking bench for matmul_unit: table vectors, random ops against a matrix model, corner sequences.
module tb_matmul_unit;

  logic        clk;
  logic        rst_n;
  logic        MatmulE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [4:0]  RdE;
  logic        MatmulBusy;
  logic        MatmulWeW;
  logic [4:0]  MatmulRdW;
  logic [31:0] MatmulResultW;

  int n_checks = 0;
  int n_fail   = 0;

  matmul_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MatmulE       (MatmulE),
    .SrcAE         (SrcAE),
    .SrcBE         (SrcBE),
    .RdE           (RdE),
    .MatmulBusy    (MatmulBusy),
    .MatmulWeW     (MatmulWeW),
    .MatmulRdW     (MatmulRdW),
    .MatmulResultW (MatmulResultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // C[i][j] = clamp(sum_k A[i][k]*B[k][j]); element (r,c) lives in byte 2r+c.
  function automatic logic [31:0] ref_mm(input logic [31:0] a, input logic [31:0] b);
    int ma[2][2];
    int mb[2][2];
    int s;
    logic [31:0] r;
    logic [7:0]  t;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        t = a[(2*i+j)*8 +: 8];
        ma[i][j] = int'($signed(t));
        t = b[(2*i+j)*8 +: 8];
        mb[i][j] = int'($signed(t));
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = ma[i][0] * mb[0][j] + ma[i][1] * mb[1][j];
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        r[(2*i+j)*8 +: 8] = 8'(s);
      end
    end
    return r;
  endfunction

  // Issue in cycle 0, then check busy, write enable and result through cycle 10.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    @(posedge clk);
    #1;
    MatmulE = 1'b1;
    SrcAE   = a;
    SrcBE   = b;
    RdE     = rd;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      check({tag, " busy"}, 32'(MatmulBusy), 32'(c <= 9));
      check({tag, " wew"}, 32'(MatmulWeW), 32'((c == 9) && (rd != 5'd0)));
      if ((c == 9 || c == 10) && rd != 5'd0) begin
        check({tag, " rd"}, 32'(MatmulRdW), 32'(rd));
        check({tag, " result"}, MatmulResultW, exp);
      end
      @(posedge clk);
      #1;
      MatmulE = 1'b0;
      SrcAE   = $urandom;
      SrcBE   = $urandom;
      RdE     = 5'($urandom);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;

    vecs[0] = '{"identity", 32'h01000001, 32'h04030201, 5'd5,  32'h04030201};
    vecs[1] = '{"mixed",    32'h02FF01FE, 32'h01020304, 5'd7,  32'hFF00FBFA};
    vecs[2] = '{"sat_pos",  32'h7F7F7F7F, 32'h7F7F7F7F, 5'd31, 32'h7F7F7F7F};
    vecs[3] = '{"sat_neg",  32'h80808080, 32'h7F7F7F7F, 5'd1,  32'h80808080};
    vecs[4] = '{"rd_zero",  32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h00000000};

    rst_n   = 1'b0;
    MatmulE = 1'b0;
    SrcAE   = '0;
    SrcBE   = '0;
    RdE     = '0;
    #2;
    check("reset busy", 32'(MatmulBusy), 32'd0);
    check("reset wew", 32'(MatmulWeW), 32'd0);
    check("reset rd", 32'(MatmulRdW), 32'd0);
    check("reset result", MatmulResultW, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].rd, vecs[v].exp);
    end

    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("random", ra, rb, 5'($urandom_range(0, 31)), ref_mm(ra, rb));
    end

    // Reset asserted in cycle 4 of an op: everything drops at once, no write follows.
    @(posedge clk);
    #1;
    MatmulE = 1'b1;
    SrcAE   = 32'h7F7F7F7F;
    SrcBE   = 32'h01010101;
    RdE     = 5'd9;
    @(posedge clk);
    #1;
    MatmulE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst busy before", 32'(MatmulBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(MatmulBusy), 32'd0);
    check("midrst wew", 32'(MatmulWeW), 32'd0);
    check("midrst rd", 32'(MatmulRdW), 32'd0);
    check("midrst result", MatmulResultW, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("postrst busy", 32'(MatmulBusy), 32'd0);
      check("postrst wew", 32'(MatmulWeW), 32'd0);
    end
    run_op("after_reset", 32'h01000001, 32'h04030201, 5'd5, 32'h04030201);

    // MatmulE held through cycles 0-12: second op only at cycle 10, WB at 19.
    a1 = 32'h02FF01FE;
    b1 = 32'h01020304;
    a2 = $urandom;
    b2 = $urandom;
    @(posedge clk);
    #1;
    MatmulE = 1'b1;
    SrcAE   = a1;
    SrcBE   = b1;
    RdE     = 5'd3;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      check("b2b busy", 32'(MatmulBusy), 32'(c <= 19));
      check("b2b wew", 32'(MatmulWeW), 32'((c == 9) || (c == 19)));
      if (c == 9) begin
        check("b2b rd1", 32'(MatmulRdW), 32'd3);
        check("b2b result1", MatmulResultW, ref_mm(a1, b1));
      end
      if (c == 19) begin
        check("b2b rd2", 32'(MatmulRdW), 32'd12);
        check("b2b result2", MatmulResultW, ref_mm(a2, b2));
      end
      @(posedge clk);
      #1;
      MatmulE = (c + 1 <= 12);
      SrcAE   = a2;
      SrcBE   = b2;
      RdE     = 5'd12;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
